fp_mult_seq: RTL

FP_MULT_SEQ -- requirements
Module: fp_mult_seq

---
 rtl/fp32_pkg.sv | 43 ++++
 rtl/fp_mult_pp_unit.sv | 46 ++++
 rtl/fp_mult_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared types and constants for the sequential single-precision multiplier.
package fp32_pkg;

  localparam int          FP32_BIAS    = 127;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    PASS_HI,
    PASS_LO,
    ROUND,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_t;

  // Which slice of the B mantissa the partial-product unit works on this cycle.
  typedef enum logic [1:0] {
    PP_HOLD,
    PP_HI,
    PP_LO
  } pp_sel_t;

  // Denormals are grouped with zero: the datapath only handles normal operands.
  function automatic fp_class_t fp_classify(input logic [31:0] x);
    fp_class_t cls;
    if (x[30:23] == FP32_EXP_MAX) begin
      cls = (x[22:0] != 23'd0) ? NAN : INF;
    end else if (x[30:23] == 8'd0) begin
      cls = ZERO;
    end else begin
      cls = NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fp_mult_pp_unit.sv
// Shared 24x18 multiplier with a 48-bit shift-accumulate. The 24-bit A mantissa
// is multiplied by either the top 7 bits or the low 17 bits of the B mantissa;
// the low pass shifts the earlier partial product up by 17 before adding.
module fp_mult_pp_unit
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  pp_sel_t     i_sel,
  input  logic [23:0] i_mant_a,
  input  logic [22:0] i_frac_b,
  output logic [47:0] o_acc
);

  logic [17:0] w_op_b;
  logic [41:0] w_prod;
  logic [47:0] r_acc;

  // Select the B operand slice for the current pass (hidden bit joins the high slice).
  always_comb begin
    w_op_b = 18'd0;
    case (i_sel)
      PP_HI:   w_op_b = {11'd0, 1'b1, i_frac_b[22:17]};
      PP_LO:   w_op_b = {1'b0, i_frac_b[16:0]};
      default: w_op_b = 18'd0;
    endcase
  end

  assign w_prod = {18'd0, i_mant_a} * {24'd0, w_op_b};

  // Accumulate: high pass loads, low pass folds in the shifted high result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= 48'd0;
    end else begin
      case (i_sel)
        PP_HI:   r_acc <= {6'd0, w_prod};
        PP_LO:   r_acc <= {r_acc[30:0], 17'd0} + {6'd0, w_prod};
        default: r_acc <= r_acc;
      endcase
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/fp_mult_seq.sv
// Sequential IEEE-754 single-precision multiplier: two multiply passes, one
// normalise/round cycle, then a held result until the consumer accepts it.
//
//   state   | meaning
//   --------+----------------------------------------------------
//   IDLE    | ready for an operand pair
//   PASS_HI | A mantissa x top 7 bits of B mantissa
//   PASS_LO | shift-accumulate A mantissa x low 17 bits of B
//   ROUND   | normalise, round-to-nearest-even, resolve specials
//   DONE    | result valid and held until out_ready
module fp_mult_seq
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic        r_out_valid;

  pp_sel_t     w_pp_sel;
  logic [47:0] w_mp;

  logic        w_ovf;
  logic [22:0] w_frac;
  logic        w_g;
  logic        w_r;
  logic        w_s;
  logic        w_inc;
  logic [23:0] w_frac_rnd;
  logic [9:0]  w_exp_raw;
  logic [9:0]  w_exp_adj;
  logic signed [9:0] w_exp_fin;

  logic        w_sign;
  fp_class_t   w_cls_a;
  fp_class_t   w_cls_b;
  logic [31:0] w_result;

  // Drive the multiplier slice select from the current state.
  always_comb begin
    w_pp_sel = PP_HOLD;
    case (r_state)
      PASS_HI: w_pp_sel = PP_HI;
      PASS_LO: w_pp_sel = PP_LO;
      default: w_pp_sel = PP_HOLD;
    endcase
  end

  fp_mult_pp_unit u_pp (
    .clk      (clk),
    .rst      (rst),
    .i_sel    (w_pp_sel),
    .i_mant_a ({1'b1, r_a[22:0]}),
    .i_frac_b (r_b[22:0]),
    .o_acc    (w_mp)
  );

  // Normalise the 48-bit product and round to nearest even.
  always_comb begin
    w_ovf = w_mp[47];
    if (w_ovf) begin
      w_frac = w_mp[46:24];
      w_g    = w_mp[23];
      w_r    = w_mp[22];
      w_s    = |w_mp[21:0];
    end else begin
      w_frac = w_mp[45:23];
      w_g    = w_mp[22];
      w_r    = w_mp[21];
      w_s    = |w_mp[20:0];
    end
    w_inc      = w_g & (w_r | w_s | w_frac[0]);
    // A carry out of the fraction leaves its low 23 bits at zero, as required.
    w_frac_rnd = {1'b0, w_frac} + {23'd0, w_inc};
    w_exp_raw  = {2'b00, r_a[30:23]} + {2'b00, r_b[30:23]} - 10'(FP32_BIAS) + {9'd0, w_ovf};
    w_exp_adj  = w_exp_raw + {9'd0, w_frac_rnd[23]};
    w_exp_fin  = $signed(w_exp_adj);
  end

  // Special operands override the arithmetic path, then range clamping applies.
  always_comb begin
    w_sign  = r_a[31] ^ r_b[31];
    w_cls_a = fp_classify(r_a);
    w_cls_b = fp_classify(r_b);
    if ((w_cls_a == NAN) || (w_cls_b == NAN) ||
        ((w_cls_a == INF) && (w_cls_b == ZERO)) ||
        ((w_cls_a == ZERO) && (w_cls_b == INF))) begin
      w_result = FP32_QNAN;
    end else if ((w_cls_a == INF) || (w_cls_b == INF)) begin
      w_result = {w_sign, FP32_EXP_MAX, 23'd0};
    end else if ((w_cls_a == ZERO) || (w_cls_b == ZERO)) begin
      w_result = {w_sign, 31'd0};
    end else if (w_exp_fin >= 10'sd255) begin
      w_result = {w_sign, FP32_EXP_MAX, 23'd0};
    end else if (w_exp_fin <= 10'sd0) begin
      w_result = {w_sign, 31'd0};
    end else begin
      w_result = {w_sign, w_exp_fin[7:0], w_frac_rnd[22:0]};
    end
  end

  // Control FSM with registered result and valid; operands only load in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= 32'd0;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_state <= PASS_HI;
          end
        end
        PASS_HI: r_state <= PASS_LO;
        PASS_LO: r_state <= ROUND;
        ROUND: begin
          r_result    <= w_result;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule
